// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: opcode encoding and control FSM states.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_DIV = 2'b00,
    OP_SUB = 2'b01,
    OP_ADD = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EXEC = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_divider.sv
// WIDTH-cycle unsigned restoring divider; the first step runs in the start cycle
// so quotient/remainder are valid combinationally while o_done is high.
import serial_alu_pkg::*;

module serial_alu_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;

  logic             w_step;
  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] w_remIn;
  logic [WIDTH-1:0] w_quoIn;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;

  // The quotient register starts as the dividend; dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    w_step  = i_start | r_active;
    w_cnt   = i_start ? '0 : r_cnt;
    w_remIn = i_start ? '0 : r_rem;
    w_quoIn = i_start ? i_dividend : r_quo;
    w_trial = {w_remIn, w_quoIn[WIDTH-1]} - {1'b0, i_divisor};
    if (w_trial[WIDTH]) begin
      w_remNext = {w_remIn[WIDTH-2:0], w_quoIn[WIDTH-1]};
      w_quoNext = {w_quoIn[WIDTH-2:0], 1'b0};
    end else begin
      w_remNext = w_trial[WIDTH-1:0];
      w_quoNext = {w_quoIn[WIDTH-2:0], 1'b1};
    end
  end

  assign o_done      = w_step && (w_cnt == CNT_W'(WIDTH - 1));
  assign o_quotient  = w_quoNext;
  assign o_remainder = w_remNext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else if (w_step) begin
      r_rem <= w_remNext;
      r_quo <= w_quoNext;
      if (o_done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_active <= 1'b1;
        r_cnt    <= w_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_alu_n.sv
// Bit-serial add/sub/mul/div ALU with a 2*WIDTH-bit serial result frame.
// Define SERIAL_ALU_PARITY_EN to append an even-parity bit after the result LSB.
import serial_alu_pkg::*;

module serial_alu_n #(
  parameter int WIDTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic data_in,
  input  logic data_valid,
  output logic data_out,
  output logic out_valid,
  output logic busy,
  output logic div_zero
);

  localparam int FRAME = 2 + 2 * WIDTH;
  localparam int RES_W = 2 * WIDTH;
`ifdef SERIAL_ALU_PARITY_EN
  localparam int OUT_LEN = RES_W + 1;
`else
  localparam int OUT_LEN = RES_W;
`endif
  localparam int BIT_CNT_W  = $clog2(FRAME);
  localparam int SEND_CNT_W = $clog2(OUT_LEN);
  localparam int EXEC_CNT_W = $clog2(WIDTH);

  state_e                r_state;
  state_e                w_nextState;
  logic [FRAME-1:0]      r_frame;
  logic [BIT_CNT_W-1:0]  r_bitCnt;
  logic [EXEC_CNT_W-1:0] r_execCnt;
  logic [SEND_CNT_W-1:0] r_sendCnt;
  logic [RES_W-1:0]      r_mulAcc;
  logic [OUT_LEN-1:0]    r_shift;
  logic                  r_dataOut;
  logic                  r_outValid;
  logic                  r_divZero;

  op_e              w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_bZero;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [RES_W-1:0] w_mulNext;
  logic [RES_W-1:0] w_result;
  logic [OUT_LEN-1:0] w_frameOut;
  logic             w_execDone;
  logic             w_frameEnd;
  logic             w_sendLast;
  logic             w_divStart;
  logic             w_divDone;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_op    = op_e'(r_frame[FRAME-1 -: 2]);
  assign w_a     = r_frame[2*WIDTH-1 -: WIDTH];
  assign w_b     = r_frame[WIDTH-1:0];
  assign w_bZero = (w_b == '0);
  assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff  = {1'b0, w_a} - {1'b0, w_b};

  // One shift-add step per EXEC cycle; the final step feeds the result directly.
  assign w_mulNext = r_mulAcc + (w_b[r_execCnt] ? (RES_W'(w_a) << r_execCnt) : '0);

  assign w_divStart = (r_state == EXEC) && (w_op == OP_DIV) && !w_bZero && (r_execCnt == '0);

  serial_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clock       (clock),
    .reset       (reset),
    .i_start     (w_divStart),
    .i_dividend  (w_a),
    .i_divisor   (w_b),
    .o_done      (w_divDone),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_comb begin
    w_result   = '1;
    w_execDone = 1'b1;
    case (w_op)
      OP_ADD: w_result = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB: w_result = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
      OP_MUL: begin
        w_result   = w_mulNext;
        w_execDone = (r_execCnt == EXEC_CNT_W'(WIDTH - 1));
      end
      OP_DIV: begin
        if (!w_bZero) begin
          w_result   = {w_quo, w_rem};
          w_execDone = w_divDone;
        end
      end
      default: ;
    endcase
  end

`ifdef SERIAL_ALU_PARITY_EN
  assign w_frameOut = {w_result, ^w_result};
`else
  assign w_frameOut = w_result;
`endif

  assign w_frameEnd = (r_bitCnt == BIT_CNT_W'(FRAME - 1));
  assign w_sendLast = (r_sendCnt == SEND_CNT_W'(OUT_LEN - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RECV;
    else       r_state <= w_nextState;
  end

  // SEND ends on the edge that loads the last output bit, so the next frame can
  // start arriving while that bit is still on data_out.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RECV: if (data_valid && w_frameEnd) w_nextState = EXEC;
      EXEC: if (w_execDone) w_nextState = SEND;
      SEND: if (w_sendLast) w_nextState = RECV;
      default: w_nextState = RECV;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame    <= '0;
      r_bitCnt   <= '0;
      r_execCnt  <= '0;
      r_sendCnt  <= '0;
      r_mulAcc   <= '0;
      r_shift    <= '0;
      r_dataOut  <= 1'b0;
      r_outValid <= 1'b0;
      r_divZero  <= 1'b0;
    end else begin
      case (r_state)
        RECV: begin
          r_outValid <= 1'b0;
          r_dataOut  <= 1'b0;
          r_execCnt  <= '0;
          r_mulAcc   <= '0;
          if (data_valid) begin
            r_frame <= {r_frame[FRAME-2:0], data_in};
            if (r_bitCnt == '0) r_divZero <= 1'b0;
            r_bitCnt <= w_frameEnd ? '0 : r_bitCnt + BIT_CNT_W'(1);
          end
        end
        EXEC: begin
          if (w_execDone) begin
            r_shift    <= w_frameOut;
            r_dataOut  <= w_frameOut[OUT_LEN-1];
            r_outValid <= 1'b1;
            r_sendCnt  <= SEND_CNT_W'(1);
            r_execCnt  <= '0;
            if ((w_op == OP_DIV) && w_bZero) r_divZero <= 1'b1;
          end else begin
            r_execCnt <= r_execCnt + EXEC_CNT_W'(1);
            r_mulAcc  <= w_mulNext;
          end
        end
        SEND: begin
          r_shift   <= r_shift << 1;
          r_dataOut <= r_shift[OUT_LEN-2];
          r_sendCnt <= w_sendLast ? '0 : r_sendCnt + SEND_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_out  = r_dataOut;
  assign out_valid = r_outValid;
  assign busy      = (r_state != RECV);
  assign div_zero  = r_divZero;

endmodule

// File: tb/tb_serial_alu_n.sv
// Directed self-checking bench for serial_alu_n (WIDTH=4) with a result scoreboard.
// Honours SERIAL_ALU_PARITY_EN to expect the trailing parity bit.
module tb_serial_alu_n;

  localparam int WIDTH = 4;
  localparam int RES_W = 2 * WIDTH;
`ifdef SERIAL_ALU_PARITY_EN
  localparam int OUT_LEN = RES_W + 1;
`else
  localparam int OUT_LEN = RES_W;
`endif
  localparam int TIMEOUT = 100;

  logic clock = 1'b0;
  logic reset;
  logic data_in;
  logic data_valid;
  logic data_out;
  logic out_valid;
  logic busy;
  logic div_zero;

  int vectors = 0;
  int miscompares = 0;

  logic [OUT_LEN-1:0] expResultQ[$];
  int                 expLatencyQ[$];
  logic               expDivZeroQ[$];

  serial_alu_n #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference results computed with plain integer arithmetic.
  function automatic logic [OUT_LEN-1:0] modelResult(input logic [1:0] op, input int a, input int b);
    int r;
    logic [RES_W-1:0] res;
    case (op)
      2'b10:   r = a + b;
      2'b01:   r = a - b;
      2'b11:   r = a * b;
      default: r = (b == 0) ? -1 : (((a / b) << WIDTH) | (a % b));
    endcase
    res = r[RES_W-1:0];
`ifdef SERIAL_ALU_PARITY_EN
    return {res, ^res};
`else
    return res;
`endif
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit gapped, input bit xAfter);
    logic [2*WIDTH+1:0] frame;
    frame = {op, a, b};
    expResultQ.push_back(modelResult(op, int'(a), int'(b)));
    expLatencyQ.push_back(((op == 2'b11) || (op == 2'b00 && b != '0)) ? WIDTH : 1);
    expDivZeroQ.push_back(op == 2'b00 && b == '0);
    for (int i = 2 * WIDTH + 1; i >= 0; i--) begin
      if (gapped && (i % 3 == 0)) begin
        @(negedge clock);
        data_valid = 1'b0;
        data_in    = 1'bx;
      end
      @(negedge clock);
      data_valid = 1'b1;
      data_in    = frame[i];
      if (i == 2 * WIDTH) begin
        checkOutput("divZeroClearedOnFirstBit", 32'(div_zero), 32'(1'b0));
        checkOutput("busyLowInRecv", 32'(busy), 32'(1'b0));
      end
    end
    @(posedge clock);
    @(negedge clock);
    data_valid = xAfter ? 1'bx : 1'b0;
    data_in    = xAfter ? 1'bx : 1'b0;
    checkOutput("busyInExec", 32'(busy), 32'(1'b1));
  endtask

  task automatic waitOutValid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < TIMEOUT) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic collectResult(input string tag);
    int cycles;
    int validCnt;
    int expLat;
    logic expDz;
    logic [OUT_LEN-1:0] got;
    logic [OUT_LEN-1:0] expRes;
    expRes = expResultQ.pop_front();
    expLat = expLatencyQ.pop_front();
    expDz  = expDivZeroQ.pop_front();
    waitOutValid(cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_divZero"}, 32'(div_zero), 32'(expDz));
    validCnt = 0;
    got = '0;
    for (int i = 0; i < OUT_LEN; i++) begin
      got = {got[OUT_LEN-2:0], data_out};
      if (out_valid === 1'b1) validCnt++;
      if (i == OUT_LEN - 1) begin
        data_valid = 1'b0;
        data_in    = 1'b0;
      end
      @(negedge clock);
    end
    checkOutput({tag, "_result"}, 32'(got), 32'(expRes));
    checkOutput({tag, "_validCycles"}, 32'(validCnt), 32'(OUT_LEN));
    checkOutput({tag, "_validDropped"}, 32'(out_valid), 32'(1'b0));
    checkOutput({tag, "_dataOutIdle"}, 32'(data_out), 32'(1'b0));
    checkOutput({tag, "_busyIdle"}, 32'(busy), 32'(1'b0));
    checkOutput({tag, "_divZeroHeld"}, 32'(div_zero), 32'(expDz));
  endtask

  initial begin
    int cycles;
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_dataOut", 32'(data_out), 32'(1'b0));
    checkOutput("reset_outValid", 32'(out_valid), 32'(1'b0));
    checkOutput("reset_busy", 32'(busy), 32'(1'b0));
    checkOutput("reset_divZero", 32'(div_zero), 32'(1'b0));
    reset = 1'b0;
    $display("[TB] reset released");

    applyStimulus(2'b10, 4'b0011, 4'b0001, 1'b0, 1'b0);
    collectResult("add3p1");
    applyStimulus(2'b11, 4'b0101, 4'b0010, 1'b0, 1'b0);
    collectResult("mul5x2");
    applyStimulus(2'b01, 4'b1101, 4'b0100, 1'b0, 1'b0);
    collectResult("sub13m4");
    applyStimulus(2'b01, 4'b0100, 4'b1101, 1'b0, 1'b0);
    collectResult("sub4m13");
    applyStimulus(2'b00, 4'b1001, 4'b0011, 1'b0, 1'b0);
    collectResult("div9by3");
    applyStimulus(2'b00, 4'b1001, 4'b0000, 1'b0, 1'b0);
    collectResult("div9by0");
    applyStimulus(2'b10, 4'b1111, 4'b1111, 1'b0, 1'b0);
    collectResult("addCarry");
    applyStimulus(2'b10, 4'b0011, 4'b0001, 1'b1, 1'b1);
    collectResult("addGappedX");
    applyStimulus(2'b11, 4'b1111, 4'b1111, 1'b1, 1'b1);
    collectResult("mul15x15GappedX");
    applyStimulus(2'b00, 4'b0010, 4'b0111, 1'b0, 1'b1);
    collectResult("div2by7");
    applyStimulus(2'b01, 4'b0000, 4'b1111, 1'b0, 1'b0);
    collectResult("sub0m15");

    // Reset in the third SEND cycle of a divide-by-zero frame.
    applyStimulus(2'b00, 4'b1001, 4'b0000, 1'b0, 1'b1);
    waitOutValid(cycles);
    checkOutput("rstSend_latency", 32'(cycles), 32'(1));
    @(negedge clock);
    @(negedge clock);
    checkOutput("rstSend_divZeroBefore", 32'(div_zero), 32'(1'b1));
    data_valid = 1'b0;
    data_in    = 1'b0;
    reset      = 1'b1;
    #1;
    checkOutput("rstSend_outValid", 32'(out_valid), 32'(1'b0));
    checkOutput("rstSend_dataOut", 32'(data_out), 32'(1'b0));
    checkOutput("rstSend_busy", 32'(busy), 32'(1'b0));
    checkOutput("rstSend_divZero", 32'(div_zero), 32'(1'b0));
    void'(expResultQ.pop_front());
    void'(expLatencyQ.pop_front());
    void'(expDivZeroQ.pop_front());
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2'b10, 4'b0011, 4'b0001, 1'b0, 1'b0);
    collectResult("addAfterReset");

    // Reset part-way through receiving a frame; the partial bits must be discarded.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      data_valid = 1'b1;
      data_in    = 1'b1;
    end
    @(negedge clock);
    data_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2'b00, 4'b1111, 4'b0100, 1'b0, 1'b0);
    collectResult("div15by4AfterPartial");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
